adc_spi_responder: RTL

ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

---
 rtl/adc_spi_responder_if.sv | 28 ++
 rtl/adc_spi_responder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/adc_spi_responder_if.sv
// Signal bundle between an SPI initiator / sample host and the ADC SPI responder.
// The master modport is the initiator/host side, the slave modport is the responder.
interface adc_spi_responder_if #(
    parameter int DATA_BITS = 12,
    parameter int CFG_BITS  = 6
);
    logic                 adc_sclk;
    logic                 adc_cs_n;
    logic                 adc_din;
    logic                 adc_dout;
    logic                 conv_req;
    logic [CFG_BITS-1:0]  conv_cfg;
    logic [DATA_BITS-1:0] sample_in;
    logic                 sample_valid;
    logic                 frame_done;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output adc_sclk, adc_cs_n, adc_din, sample_in, sample_valid,
        input  adc_dout, conv_req, conv_cfg, frame_done, frame_err, overrun
    );

    modport slave (
        input  adc_sclk, adc_cs_n, adc_din, sample_in, sample_valid,
        output adc_dout, conv_req, conv_cfg, frame_done, frame_err, overrun
    );
endinterface

// File: rtl/adc_spi_responder.sv
// SPI mode-0 responder: shifts in a config word, requests a conversion and
// returns the previously delivered sample in the following frame.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no frame in progress, no conversion pending
// SHIFT   | cs_n low: receiving config bits, transmitting result bits
// CONVERT | conversion requested, waiting for sample_valid from host
module adc_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_BITS   = 12,
    parameter int CFG_BITS    = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    adc_spi_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, CONVERT} state_t;

    localparam logic [4:0] CFG_CNT = 5'(CFG_BITS);

    state_t r_state, w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_din_sync;
    logic                   r_sclk_prev, r_cs_prev;
    logic                   w_sclk, w_cs_n, w_din;
    logic                   w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;

    logic [DATA_BITS-1:0] r_tx, w_tx_nxt, r_shift, w_shift_nxt, w_frame_data;
    logic [CFG_BITS-1:0]  r_cfg_sh, w_cfg_sh_nxt, r_conv_cfg, w_conv_cfg_nxt;
    logic [4:0]           r_bit_cnt, w_bit_cnt_nxt;
    logic                 r_dout, w_dout_nxt;
    logic                 r_conv_req, w_conv_req_nxt;
    logic                 r_frame_done, w_frame_done_nxt;
    logic                 r_frame_err, w_frame_err_nxt;
    logic                 r_overrun, w_overrun_nxt;
    logic                 w_start;

    // Reset values make the idle line look like cs_n high, sclk low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_din_sync  <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.adc_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.adc_cs_n};
            r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], bus.adc_din};
            r_sclk_prev <= w_sclk;
            r_cs_prev   <= w_cs_n;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_n      = r_cs_sync[SYNC_STAGES-1];
    assign w_din       = r_din_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk & r_sclk_prev;
    assign w_cs_rise   = w_cs_n & ~r_cs_prev;
    assign w_cs_fall   = ~w_cs_n & r_cs_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_tx         <= '0;
            r_shift      <= '0;
            r_cfg_sh     <= '0;
            r_bit_cnt    <= '0;
            r_conv_cfg   <= '0;
            r_dout       <= 1'b0;
            r_conv_req   <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_tx         <= w_tx_nxt;
            r_shift      <= w_shift_nxt;
            r_cfg_sh     <= w_cfg_sh_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_conv_cfg   <= w_conv_cfg_nxt;
            r_dout       <= w_dout_nxt;
            r_conv_req   <= w_conv_req_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_overrun    <= w_overrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_tx_nxt         = r_tx;
        w_shift_nxt      = r_shift;
        w_cfg_sh_nxt     = r_cfg_sh;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_conv_cfg_nxt   = r_conv_cfg;
        w_dout_nxt       = r_dout;
        w_conv_req_nxt   = 1'b0;
        w_frame_done_nxt = 1'b0;
        w_frame_err_nxt  = 1'b0;
        w_overrun_nxt    = 1'b0;
        w_start          = 1'b0;
        w_frame_data     = r_tx;

        unique case (r_state)
            IDLE: begin
                if (w_cs_fall) w_start = 1'b1;
            end
            SHIFT: begin
                if (w_cs_rise) begin
                    w_dout_nxt = 1'b0;
                    if (r_bit_cnt >= CFG_CNT) begin
                        w_state_nxt      = CONVERT;
                        w_conv_cfg_nxt   = r_cfg_sh;
                        w_conv_req_nxt   = 1'b1;
                        w_frame_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = IDLE;
                        w_frame_err_nxt = 1'b1;
                    end
                end else if (!w_cs_n) begin
                    if (w_sclk_rise) begin
                        if (r_bit_cnt < CFG_CNT) w_cfg_sh_nxt = {r_cfg_sh[CFG_BITS-2:0], w_din};
                        if (r_bit_cnt != 5'd31)  w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                    end
                    // Zero fill means the line reads 0 once all result bits are out.
                    if (w_sclk_fall) begin
                        w_dout_nxt  = r_shift[DATA_BITS-1];
                        w_shift_nxt = r_shift << 1;
                    end
                end
            end
            CONVERT: begin
                if (w_cs_fall) begin
                    w_start = 1'b1;
                    if (bus.sample_valid) begin
                        w_tx_nxt     = bus.sample_in;
                        w_frame_data = bus.sample_in;
                    end else begin
                        w_tx_nxt      = '0;
                        w_frame_data  = '0;
                        w_overrun_nxt = 1'b1;
                    end
                end else if (bus.sample_valid) begin
                    w_tx_nxt    = bus.sample_in;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_start) begin
            w_state_nxt   = SHIFT;
            w_dout_nxt    = w_frame_data[DATA_BITS-1];
            w_shift_nxt   = w_frame_data << 1;
            w_bit_cnt_nxt = '0;
            w_cfg_sh_nxt  = '0;
        end
    end

    assign bus.adc_dout   = r_dout;
    assign bus.conv_req   = r_conv_req;
    assign bus.conv_cfg   = r_conv_cfg;
    assign bus.frame_done = r_frame_done;
    assign bus.frame_err  = r_frame_err;
    assign bus.overrun    = r_overrun;
endmodule
